// File: rtl/mux_sel_arbiter.sv
// Round-robin, packet-locking select generator for an N-to-1 datapath mux.
// Optional same-cycle re-arbitration on release: define MUX_SEL_ARB_FAST_REARB_EN.
module mux_sel_arbiter #(
    parameter  int SIZE     = 8,
    localparam int LOG_SIZE = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SIZE-1:0]     req,
    input  logic [SIZE-1:0]     req_tail,
    input  logic                advance,
    output logic                valid,
    output logic [LOG_SIZE-1:0] sel_e,
    output logic [SIZE-1:0]     sel_d,
    output logic                dbg_state_o
);

    // Handshake: a flit moves on any cycle where advance=1 and req[sel_e]=1
    // while valid=1; advance with no request on the granted input is ignored.

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LOG_SIZE-1:0] ptr_q, ptr_d;
    logic [LOG_SIZE-1:0] sel_e_q, sel_e_d;
    logic [SIZE-1:0]     sel_d_q, sel_d_d;
    logic                xfer;
    logic                rel;
    logic [LOG_SIZE:0]   pick_idle;
`ifdef MUX_SEL_ARB_FAST_REARB_EN
    logic [LOG_SIZE:0]   pick_rel;
`endif

    // Returns {found, index}: first set bit of r searching circularly from last+1.
    function automatic logic [LOG_SIZE:0] rr_pick(input logic [SIZE-1:0]     r,
                                                   input logic [LOG_SIZE-1:0] last);
        logic                found;
        logic [LOG_SIZE-1:0] idx;
        int                  c;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= SIZE; i++) begin
            c = (int'(last) + i) % SIZE;
            if (!found && r[c]) begin
                found = 1'b1;
                idx   = LOG_SIZE'(c);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [SIZE-1:0] decode(input logic [LOG_SIZE-1:0] idx);
        logic [SIZE-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= LOG_SIZE'(SIZE - 1);
            sel_e_q <= '0;
            sel_d_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_e_q <= sel_e_d;
            sel_d_q <= sel_d_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_e_d   = sel_e_q;
        sel_d_d   = sel_d_q;
        xfer      = advance && req[sel_e_q];
        rel       = xfer && req_tail[sel_e_q];
        pick_idle = rr_pick(req, ptr_q);
`ifdef MUX_SEL_ARB_FAST_REARB_EN
        pick_rel  = rr_pick(req, sel_e_q);
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_idle[LOG_SIZE]) begin
                    state_d = ST_LOCKED;
                    sel_e_d = pick_idle[LOG_SIZE-1:0];
                    sel_d_d = decode(pick_idle[LOG_SIZE-1:0]);
                end
            end
            ST_LOCKED: begin
                // Only the tail transfer of the granted input ends the packet.
                if (rel) begin
                    ptr_d = sel_e_q;
`ifdef MUX_SEL_ARB_FAST_REARB_EN
                    if (pick_rel[LOG_SIZE]) begin
                        sel_e_d = pick_rel[LOG_SIZE-1:0];
                        sel_d_d = decode(pick_rel[LOG_SIZE-1:0]);
                    end else begin
                        state_d = ST_IDLE;
                        sel_d_d = '0;
                    end
`else
                    state_d = ST_IDLE;
                    sel_d_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d_d = '0;
            end
        endcase
    end

    assign valid       = (state_q == ST_LOCKED);
    assign sel_e       = sel_e_q;
    assign sel_d       = sel_d_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter (SIZE=8); expectations follow the build's
// MUX_SEL_ARB_FAST_REARB_EN setting.
module tb_mux_sel_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] req_tail = '0;
    logic       advance = 1'b0;
    logic       valid;
    logic [2:0] sel_e;
    logic [7:0] sel_d;
    logic       dbg_state;

    int total = 0;
    int bad   = 0;

    mux_sel_arbiter #(.SIZE(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_tail    (req_tail),
        .advance     (advance),
        .valid       (valid),
        .sel_e       (sel_e),
        .sel_d       (sel_d),
        .dbg_state_o (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] e,
                           input logic [7:0] d);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".sel_e"}, 32'(sel_e), 32'(e));
        chk({tag, ".sel_d"}, 32'(sel_d), 32'(d));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".sel_d"}, 32'(sel_d), 32'd0);
    endtask

    // Called #1 after a clock edge; leaves reset released before the next edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_out("rst_pulse", 1'b0, 3'd0, 8'h00);
        req      = '0;
        req_tail = '0;
        advance  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset with random inputs, outputs cleared without a clock edge.
        #1;
        req      = 8'($urandom_range(0, 255));
        req_tail = 8'($urandom_range(0, 255));
        advance  = 1'($urandom_range(0, 1));
        reset    = 1'b1;
        #1;
        chk_out("reset_async", 1'b0, 3'd0, 8'h00);
        tick();
        chk_out("reset_held", 1'b0, 3'd0, 8'h00);
        reset    = 1'b0;
        req      = 8'h81;
        req_tail = 8'hFF;
        advance  = 1'b0;
        tick();
        chk_out("first_grant", 1'b1, 3'd0, 8'h01);
        tick();
        chk_out("first_hold", 1'b1, 3'd0, 8'h01);

        // Single-flit packet on input 2.
        do_reset();
        req      = 8'h04;
        req_tail = 8'h04;
        tick();
        chk_out("single_grant", 1'b1, 3'd2, 8'h04);
        advance = 1'b1;
        tick();
`ifdef MUX_SEL_ARB_FAST_REARB_EN
        chk_out("single_regrant", 1'b1, 3'd2, 8'h04);
`else
        chk_out("single_release", 1'b0, 3'd2, 8'h00);
        advance = 1'b0;
        req     = 8'h00;
        tick();
        chk_idle("single_idle");
`endif

        // Round-robin sweep with all inputs sending one-flit packets.
        do_reset();
        req      = 8'hFF;
        req_tail = 8'hFF;
        advance  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk_out("sweep_grant", 1'b1, 3'(k % 8), 8'(1 << (k % 8)));
`ifndef MUX_SEL_ARB_FAST_REARB_EN
            tick();
            chk_idle("sweep_bubble");
`endif
        end

        // Packet lock: 4-flit packet on input 3 while input 5 keeps requesting.
        do_reset();
        req      = 8'h28;
        req_tail = 8'h20;
        advance  = 1'b0;
        tick();
        chk_out("lock_grant", 1'b1, 3'd3, 8'h08);
        advance = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            tick();
            chk_out("lock_body", 1'b1, 3'd3, 8'h08);
        end
        req_tail = 8'h28;
        tick();
`ifdef MUX_SEL_ARB_FAST_REARB_EN
        chk_out("lock_next", 1'b1, 3'd5, 8'h20);
`else
        chk_idle("lock_release");
        tick();
        chk_out("lock_next", 1'b1, 3'd5, 8'h20);
`endif

        // Stall, then advance while the granted input has no flit.
        do_reset();
        req      = 8'h40;
        req_tail = 8'h40;
        tick();
        chk_out("stall_grant", 1'b1, 3'd6, 8'h40);
        for (int c = 0; c < 10; c++) begin
            req = 8'h40 | 8'($urandom_range(0, 255));
            tick();
            chk_out("stall_hold", 1'b1, 3'd6, 8'h40);
        end
        req      = 8'h3F;
        req_tail = 8'hFF;
        advance  = 1'b1;
        tick();
        chk_out("spurious_adv", 1'b1, 3'd6, 8'h40);

        // Mid-packet reset: move ptr to 3, lock on 4, then reset after 2 flits.
        do_reset();
        req      = 8'h08;
        req_tail = 8'h08;
        tick();
        chk_out("mid_grant3", 1'b1, 3'd3, 8'h08);
        req      = 8'h18;
        advance  = 1'b1;
        tick();
        req      = 8'h10;
        req_tail = 8'h00;
        advance  = 1'b0;
`ifndef MUX_SEL_ARB_FAST_REARB_EN
        chk_idle("mid_release3");
        tick();
`endif
        chk_out("mid_grant4", 1'b1, 3'd4, 8'h10);
        advance = 1'b1;
        for (int f = 1; f <= 2; f++) begin
            tick();
            chk_out("mid_flit", 1'b1, 3'd4, 8'h10);
        end
        reset = 1'b1;
        #1;
        chk_out("mid_reset", 1'b0, 3'd0, 8'h00);
        req     = 8'h11;
        advance = 1'b0;
        tick();
        chk_idle("mid_reset_held");
        reset = 1'b0;
        tick();
        chk_out("mid_after_reset", 1'b1, 3'd0, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        bad++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin, packet-locking arbiter that generates the select for an N-to-1 datapath mux.
- Sits directly upstream of the mux. Drives both the encoded select (sel_e) and the one-hot decoded select (sel_d) from registers, so the mux select path starts at a flop.
- A grant is held for a whole multi-flit packet and released on the accepted tail flit.

Parameters:
- SIZE, 8, number of requesters / mux inputs (≥2).
- LOG_SIZE, ceil(log2(SIZE)), derived localparam, not overridable; encoded select width.

Ports:
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req  input  SIZE  per-input request; bit i high when input i holds a flit
- req_tail  input  SIZE  per-input flag; bit i high when input i's current flit is the packet tail
- advance  input  1  downstream accepted the flit currently selected
- valid  output  1  a grant is active; sel_e and sel_d are meaningful
- sel_e  output  LOG_SIZE  encoded index of the granted input
- sel_d  output  SIZE  one-hot grant; always equals decode(sel_e) while valid, all-zero when not valid

Behaviour:
- Reset (async, immediate): valid=0, sel_e=0, sel_d=0, state=IDLE. Priority pointer ptr=SIZE-1, so input 0 has first priority.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: valid=0, sel_d=0, sel_e holds its last value (0 after reset).
  - LOCKED: valid=1, sel_e and sel_d are constant.
- IDLE → LOCKED:
  - If |req at edge n, grant the first set bit of req searching circularly from (ptr+1) mod SIZE.
  - sel_e, sel_d and valid are visible after edge n (1-cycle latency).
  - If req=0, stay IDLE.
- LOCKED:
  - A transfer occurs on a cycle with advance=1 and req[sel_e]=1.
  - advance while req[sel_e]=0 is ignored: no transfer, no release.
  - Transfer with req_tail[sel_e]=0: stay LOCKED.
  - Transfer with req_tail[sel_e]=1: release, ptr<=sel_e, go IDLE (base build).
  - advance=0: hold all outputs (stall).
  - Changes to req/req_tail on other inputs have no effect while LOCKED (packet lock). No timeout.
- Fairness: after a release, the released input has lowest priority on the next arbitration.
- Wrap-around: search index SIZE-1 wraps to 0. When ptr=SIZE-1, the search starts at 0.
- Single requester: re-granted to itself on every arbitration.
- SIZE not a power of two: indices ≥SIZE never granted. sel_e < SIZE always.
- Reset mid-packet: grant dropped immediately. Packet state is not preserved. ptr returns to SIZE-1.
- Invariant (assertable): valid ⇒ $onehot(sel_d) and sel_d == (1<<sel_e). !valid ⇒ sel_d == 0.

Optional Feature:
- Macro: MUX_SEL_ARB_FAST_REARB_EN
- Defined:
  - On a release cycle (tail transfer), the arbiter re-arbitrates in the same cycle.
  - The search starts from (sel_e+1) mod SIZE and excludes nothing else.
  - If another request, or the same input's next request, is present, the new grant loads at that edge and valid stays 1, with no bubble.
  - If none is present, go IDLE.
- Undefined:
  - Every release forces one IDLE cycle (valid=0) before the next grant.
  - Max throughput is then one packet per (length+1) cycles.

Test Plan:
- Reset: assert reset with random inputs → valid=0, sel_e=0, sel_d=0x00 immediately. Release reset with req=0x81, req_tail=0xFF, advance=0 → after 1 edge: valid=1, sel_e=0, sel_d=0x01.
- Single-flit packet: req=0x04, req_tail=0x04 → sel_e=2, sel_d=0x04 after 1 edge. advance=1 for 1 cycle → valid=0 on the next cycle (macro off). With the macro on and req still 0x04, valid stays 1 and sel_e=2.
- Round-robin sweep: SIZE=8, req=0xFF, req_tail=0xFF, advance=1 continuously:
  - Macro off: grants are 0,1,…,7,0 with valid toggling 1,0 between grants.
  - Macro on: grants 0..7,0 on consecutive cycles with valid constantly 1.
- Packet lock: input 3 granted with a 4-flit packet (req_tail[3] high only on the 4th transfer), req[5]=1 throughout, advance=1 → sel_e=3 for exactly 4 transfers, then sel_e=5. sel_d must never show 0x20 before the 4th transfer.
- Stall and spurious advance: LOCKED on input 6, advance=0 for 10 cycles → outputs unchanged. Then advance=1 with req[6]=0 and req_tail[6]=1 → no release, valid stays 1, sel_e=6.
- Reset mid-packet: LOCKED on input 4 after 2 of 3 flits, pulse reset → valid=0 immediately. With req=0x11 after reset → grant input 0 (ptr reset), not input 4.
